// File: rtl/rca_pkg.sv
// Shared types and width helpers for the ripple-carry adder sweep checker.
package rca_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

   // Sweep index: {cin, a, b}, with cin present only when it is swept.
   function automatic int idx_w(input int width, input int sweep_cin);
      return 2 * width + ((sweep_cin != 0) ? 1 : 0);
   endfunction

   // Large enough to count every vector of the widest sweep without wrapping.
   function automatic int err_w(input int width);
      return 2 * width + 2;
   endfunction

endpackage

// File: rtl/rca_settle_timer.sv
// Settle counter: counts 0..CYCLES-1 while enabled and flags the last cycle.
module rca_settle_timer
   import rca_pkg::*;
#(
   parameter int CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last_cycle
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0] cnt;

   assign last_cycle = (cnt == CW'(CYCLES - 1));

   // Wrapping on the last cycle clears the count for the next vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= last_cycle ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/rca_sweep_checker.sv
// Exhaustive sweep of an external adder: drives vectors, waits, compares with a
// golden sum and records the error count and the first failing vector.
module rca_sweep_checker
   import rca_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 2,
   parameter int SWEEP_CIN     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [WIDTH-1:0]     a,
   output logic [WIDTH-1:0]     b,
   output logic                 cin,
   input  logic [WIDTH-1:0]     sum,
   input  logic                 cout,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH+1:0]   err_count,
   output logic                 first_err_valid,
   output logic [WIDTH-1:0]     first_err_a,
   output logic [WIDTH-1:0]     first_err_b,
   output logic [WIDTH:0]       first_err_res
);

   localparam int IW = idx_w(WIDTH, SWEEP_CIN);
   localparam int EW = err_w(WIDTH);

   state_t          state;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_nxt;
   logic [2*WIDTH:0] nxt_ext;
   logic [WIDTH:0]  gold;
   logic [WIDTH:0]  res;
   logic            mismatch;
   logic            go;
   logic            last_cycle;

   assign go       = start && (state != SETTLE);
   assign gold     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign res      = {cout, sum};
   assign mismatch = (gold != res);
   assign idx_nxt  = idx + IW'(1);
   // Zero-extended so the cin bit reads 0 when cin is not swept.
   assign nxt_ext  = (2*WIDTH+1)'(idx_nxt);

   rca_settle_timer #(
      .CYCLES(SETTLE_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clr        (go),
      .en         (state == SETTLE),
      .last_cycle (last_cycle)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         idx             <= '0;
         a               <= '0;
         b               <= '0;
         cin             <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_a     <= '0;
         first_err_b     <= '0;
         first_err_res   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state           <= SETTLE;
                  idx             <= '0;
                  a               <= '0;
                  b               <= '0;
                  cin             <= 1'b0;
                  err_count       <= '0;
                  first_err_valid <= 1'b0;
                  busy            <= 1'b1;
                  done            <= 1'b0;
               end
            end
            SETTLE: begin
               if (last_cycle) begin
                  if (mismatch) begin
                     err_count <= err_count + EW'(1);
                     if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_a     <= a;
                        first_err_b     <= b;
                        first_err_res   <= res;
                     end
                  end
                  if (&idx) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx_nxt;
                     a   <= nxt_ext[2*WIDTH-1:WIDTH];
                     b   <= nxt_ext[WIDTH-1:0];
                     cin <= nxt_ext[2*WIDTH];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rca_sweep_checker.sv
// Bench: several checker instances around ideal, faulty and delayed adder models,
// with a queue of expected sweep results per instance.
module tb_rca_sweep_checker;

   typedef struct {
      int ec;
      int fev;
      int fa;
      int fb;
      int fres;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0 = 1'b1, rst_g = 1'b1;
   logic start0 = 1'b0, start_s = 1'b0, start8 = 1'b0;

   logic [3:0] a4[5], b4[5], sum4[5], fa4[5], fb4[5];
   logic       cin4[5], cout4[5];
   logic [9:0] ec4[5];
   logic [4:0] fres4[5];
   logic [7:0] a8, b8, sum8, fa8, fb8;
   logic       cin8, cout8;
   logic [17:0] ec8;
   logic [8:0] fres8;

   logic busy[6], done[6], fev[6], st[6];
   int   obs_ec[6], obs_fa[6], obs_fb[6], obs_fres[6];

   int checks = 0;
   int errors = 0;
   exp_t q[6][$];
   int el[6];
   logic dq[6];

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // fault: 0 ideal, 1 sum[0] stuck-at-0, 2 cout stuck-at-0, 3 result of previous vector
   function automatic exp_t model(input int w, input int s, input int sc, input int fault);
      exp_t e;
      int n, mask, prev, va, vb, vc, g, r;
      n = 1 << (2*w + sc);
      mask = (1 << w) - 1;
      prev = 0;
      e = '{ec: 0, fev: 0, fa: 0, fb: 0, fres: 0, cyc: n*s};
      for (int k = 0; k < n; k++) begin
         va = (k >> w) & mask;
         vb = k & mask;
         vc = (k >> (2*w)) & 1;
         g  = va + vb + vc;
         case (fault)
            1: r = g & ~1;
            2: r = g & mask;
            3: r = prev;
            default: r = g;
         endcase
         prev = g;
         if (r != g) begin
            e.ec++;
            if (e.fev == 0) begin
               e.fev = 1; e.fa = va; e.fb = vb; e.fres = r;
            end
         end
      end
      return e;
   endfunction

   for (genvar gi = 0; gi < 5; gi++) begin : g4
      logic [4:0] g, d1, d2, d3;
      assign g = {1'b0, a4[gi]} + {1'b0, b4[gi]} + {4'b0, cin4[gi]};
      always @(posedge clk) begin
         d1 <= g; d2 <= d1; d3 <= d2;
      end
      if (gi == 1)      assign {cout4[gi], sum4[gi]} = {g[4:1], 1'b0};
      else if (gi == 2) assign {cout4[gi], sum4[gi]} = {1'b0, g[3:0]};
      else if (gi == 3) assign {cout4[gi], sum4[gi]} = d2;
      else if (gi == 4) assign {cout4[gi], sum4[gi]} = d3;
      else              assign {cout4[gi], sum4[gi]} = g;

      rca_sweep_checker #(
         .WIDTH(4), .SETTLE_CYCLES(gi < 3 ? 2 : 3), .SWEEP_CIN(gi < 3 ? 0 : 1)
      ) u (
         .clk(clk), .rst(gi == 0 ? rst0 : rst_g), .start(gi == 0 ? start0 : start_s),
         .a(a4[gi]), .b(b4[gi]), .cin(cin4[gi]), .sum(sum4[gi]), .cout(cout4[gi]),
         .busy(busy[gi]), .done(done[gi]), .err_count(ec4[gi]),
         .first_err_valid(fev[gi]), .first_err_a(fa4[gi]), .first_err_b(fb4[gi]),
         .first_err_res(fres4[gi])
      );
      assign st[gi]       = (gi == 0) ? start0 : start_s;
      assign obs_ec[gi]   = 32'(ec4[gi]);
      assign obs_fa[gi]   = 32'(fa4[gi]);
      assign obs_fb[gi]   = 32'(fb4[gi]);
      assign obs_fres[gi] = 32'(fres4[gi]);
   end

   assign {cout8, sum8} = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};

   rca_sweep_checker #(
      .WIDTH(8), .SETTLE_CYCLES(1), .SWEEP_CIN(0)
   ) u8 (
      .clk(clk), .rst(rst_g), .start(start8),
      .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8),
      .busy(busy[5]), .done(done[5]), .err_count(ec8),
      .first_err_valid(fev[5]), .first_err_a(fa8), .first_err_b(fb8),
      .first_err_res(fres8)
   );
   assign st[5]       = start8;
   assign obs_ec[5]   = 32'(ec8);
   assign obs_fa[5]   = 32'(fa8);
   assign obs_fb[5]   = 32'(fb8);
   assign obs_fres[5] = 32'(fres8);

   // el counts edges since the start edge; done rising pops the expectation.
   always @(negedge clk) begin
      for (int i = 0; i < 6; i++) begin
         if (st[i] && !busy[i]) el[i] = -1;
         else el[i] = el[i] + 1;
         if (done[i] && !dq[i]) begin
            if (q[i].size() == 0) begin
               check($sformatf("unexpected_done%0d", i), 1, 0);
            end else begin
               exp_t e;
               e = q[i].pop_front();
               check($sformatf("err_count%0d", i), obs_ec[i], e.ec);
               check($sformatf("first_valid%0d", i), int'(fev[i]), e.fev);
               check($sformatf("sweep_cycles%0d", i), el[i], e.cyc);
               if (e.fev != 0) begin
                  check($sformatf("first_a%0d", i), obs_fa[i], e.fa);
                  check($sformatf("first_b%0d", i), obs_fb[i], e.fb);
                  check($sformatf("first_res%0d", i), obs_fres[i], e.fres);
               end
            end
         end
         dq[i] = done[i];
      end
   end

   task automatic push(input int i);
      if (i < 3)      q[i].push_back(model(4, 2, 0, i));
      else if (i < 5) q[i].push_back(model(4, 3, 1, i == 4 ? 3 : 0));
      else            q[i].push_back(model(8, 1, 0, 0));
   endtask

   task automatic wait_done(input int i, input int max);
      for (int k = 0; k < max && !done[i]; k++) @(negedge clk);
      check($sformatf("timeout%0d", i), int'(done[i]), 1);
   endtask

   initial begin
      for (int i = 0; i < 6; i++) begin el[i] = 0; dq[i] = 1'b0; end
      repeat (3) @(posedge clk);
      #1;
      check("rst_a", int'(a4[0]), 0);
      check("rst_b", int'(b4[0]), 0);
      check("rst_cin", int'(cin4[0]), 0);
      check("rst_busy", int'(busy[0]), 0);
      check("rst_done", int'(done[0]), 0);
      check("rst_ec", obs_ec[0], 0);
      check("rst_fev", int'(fev[0]), 0);
      check("rst_busy8", int'(busy[5]), 0);
      check("rst_ec8", obs_ec[5], 0);
      @(negedge clk);
      rst0 = 1'b0; rst_g = 1'b0;

      // launch all sweeps together
      @(posedge clk); #1;
      start0 = 1'b1; start_s = 1'b1; start8 = 1'b1;
      for (int i = 0; i < 6; i++) push(i);
      @(posedge clk); #1;
      start0 = 1'b0; start_s = 1'b0; start8 = 1'b0;
      check("busy_after_start", int'(busy[0]), 1);

      // start pulses while busy must be ignored
      for (int p = 0; p < 3; p++) begin
         repeat (20) @(posedge clk);
         #1 start0 = 1'b1; start_s = 1'b1;
         @(posedge clk);
         #1 start0 = 1'b0; start_s = 1'b0;
      end
      check("busy_during_pulses", int'(busy[0]), 1);
      check("done_during_pulses", int'(done[0]), 0);

      for (int i = 0; i < 5; i++) wait_done(i, 3000);
      @(posedge clk); #1;
      check("done_hold_a", int'(a4[0]), 15);
      check("done_hold_b", int'(b4[0]), 15);
      check("done_busy", int'(busy[0]), 0);

      // restart from DONE, then reset mid-sweep
      start0 = 1'b1; push(0);
      @(posedge clk); #1 start0 = 1'b0;
      repeat (98) @(posedge clk);
      #1 check("busy_before_rst", int'(busy[0]), 1);
      rst0 = 1'b1;
      #1;
      q[0].delete();
      check("midrst_a", int'(a4[0]), 0);
      check("midrst_b", int'(b4[0]), 0);
      check("midrst_busy", int'(busy[0]), 0);
      check("midrst_done", int'(done[0]), 0);
      check("midrst_ec", obs_ec[0], 0);
      check("midrst_fev", int'(fev[0]), 0);
      @(negedge clk) rst0 = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("idle_after_rst", int'(busy[0]), 0);
      start0 = 1'b1; push(0);
      @(posedge clk); #1 start0 = 1'b0;
      wait_done(0, 700);

      // wide sweep, then restart from DONE clears done on the next cycle
      wait_done(5, 70000);
      @(posedge clk); #1;
      check("w8_done", int'(done[5]), 1);
      start8 = 1'b1; push(5);
      @(posedge clk); #1 start8 = 1'b0;
      check("w8_restart_done", int'(done[5]), 0);
      check("w8_restart_busy", int'(busy[5]), 1);
      check("w8_restart_ec", obs_ec[5], 0);
      check("w8_restart_a", int'(a8), 0);
      rst_g = 1'b1;
      #1;
      q[5].delete();
      check("w8_rst_busy", int'(busy[5]), 0);
      @(negedge clk) rst_g = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) check($sformatf("queue_empty%0d", i), q[i].size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rca_sweep_checker.md
Name: rca_sweep_checker

Overview:
Self-checking sweep harness that sits around the ripple-carry adder under timing/power study. It drives exhaustive operand vectors (a, b, cin) into the adder and waits a programmable settle time. It then samples the adder's sum/carry-out, compares them against a golden a+b+cin, and accumulates the mismatch count and the first failing vector. This turns the exhaustive adder sweep into synthesizable clocked hardware, usable on silicon or FPGA with the adder as a separate instance.

Parameters:
WIDTH, 8, operand width of the adder under test (legal 2..16)
SETTLE_CYCLES, 2, clock cycles each vector is held before sampling (legal >=1)
SWEEP_CIN, 0, 0 = cin held 0; 1 = cin included as MSB of the sweep index

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a sweep
a  out  WIDTH  operand a to adder
b  out  WIDTH  operand b to adder
cin  out  1  carry-in to adder
sum  in  WIDTH  adder sum result
cout  in  1  adder carry-out ("overflow")
busy  out  1  high while sweep in progress
done  out  1  high from sweep completion until next start or reset
err_count  out  2*WIDTH+2  number of mismatching vectors in last/current sweep
first_err_valid  out  1  at least one mismatch recorded
first_err_a  out  WIDTH  a of first mismatch
first_err_b  out  WIDTH  b of first mismatch
first_err_res  out  WIDTH+1  {cout,sum} sampled at first mismatch

Behaviour:
- Reset (async assert, sync release): state IDLE; a, b, cin, busy, done, err_count, first_err_* all 0.
- Vector index idx: WIDTH*2 bits, plus 1 MSB when SWEEP_CIN=1. a=idx[2W-1:W], b=idx[W-1:0], cin=idx[2W] if SWEEP_CIN else 0. N = 2^(2W) or 2^(2W+1).
- States: IDLE, SETTLE, DONE.
- IDLE: outputs hold. start=1 -> idx=0, err_count=0, first_err_valid=0, settle counter=0, busy=1, done=0, go to SETTLE.
- SETTLE: a/b/cin are registered from idx and stable for exactly SETTLE_CYCLES cycles. On the clock edge ending the last settle cycle, compare {cout,sum} with the golden value a+b+cin. Do this WIDTH+1-bit compare combinationally on the current outputs and the sampled inputs.
  - Mismatch: err_count+1. If first_err_valid=0, capture a, b, {cout,sum} and set first_err_valid.
  - Same edge, if idx != N-1: idx+1, settle counter cleared.
  - Same edge, if idx == N-1: go to DONE, busy=0, done=1.
- Sweep length: exactly N*SETTLE_CYCLES cycles from the start edge to done=1.
- DONE: a/b/cin hold the last vector and the results hold. start=1 restarts as in IDLE, same cycle semantics.
- start while busy: ignored, no effect on idx or counters.
- err_count width holds N without wrap; no saturation logic required.
- rst mid-sweep: immediate return to reset values; the partial results are discarded.
- Golden model: a plain unsigned add of zero-extended operands, WIDTH+1 bits. No dependence on adder internals.

Decomposition:
- Shared package rca_pkg: state enum (IDLE, SETTLE, DONE), and the function for index width (2*WIDTH + SWEEP_CIN) and error-count width.
- One natural sub-module: rca_settle_timer. It is a counter 0..SETTLE_CYCLES-1 with clear input and last_cycle output. FSM, index counter, compare and capture logic stay in rca_sweep_checker.

Test Plan:
- WIDTH=4, SETTLE_CYCLES=2, SWEEP_CIN=0, ideal behavioural adder; pulse start -> done after 512 cycles, err_count=0, first_err_valid=0.
- Same config, adder with sum[0] stuck-at-0 -> err_count=128; first_err_a=0, first_err_b=1, first_err_res=5'b00000.
- Same config, cout forced 0 -> err_count=120; first_err_a=1, first_err_b=15, first_err_res=5'b00000.
- WIDTH=4, SWEEP_CIN=1, SETTLE_CYCLES=3, adder modelled with 2-cycle registered delay -> err_count=0, done after 1536 cycles. Same with 3-cycle delay -> err_count>0.
- Start pulses during busy, then rst asserted at cycle 100 mid-sweep -> start pulses ignored; after rst, all outputs 0 and state IDLE. A new start runs a full clean sweep to err_count=0.
- WIDTH=8, SETTLE_CYCLES=1, ideal adder -> done after exactly 65536 cycles, err_count=0. start in DONE restarts and clears done on the following cycle.
